multi_line_buffer: RTL and testbench

Parametrised successor to the two-entry line-buffer pair in the VGA pixel path. It holds a ring of `NUM_BUFS` tile-line buffers and runs a fill engine that prefetches tile lines from the frame buffer over the `rd_req`/`rd_rsp` handshake. The display side maps the pixel and line counters to a registered output pixel, with tile replication, blanking, and sticky underrun detection. It sits between the pixel/line counter generator and the frame buffer, and feeds the colour output stage.

---
 rtl/line_buff_pkg.sv | 41 ++++
 rtl/line_buff_ram.sv | 25 ++
 rtl/multi_line_buffer.sv | 154 +++++++++++++++
 tb/tb_multi_line_buffer.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_buff_pkg.sv
// Shared types and helpers for the tile-line ring buffer: fill FSM states,
// derived geometry constants and frame-buffer word lane selection.
package line_buff_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } fill_state_t;

    // Widest frame-buffer word and pixel the lane selector accepts
    localparam int WORD_MAX_W = 1024;
    localparam int PXL_MAX_W  = 64;

    function automatic int tile_per_line(input int width_px, input int tile_width);
        return width_px / tile_width;
    endfunction

    function automatic int rows_per_line(input int tiles_per_line, input int tile_per_row);
        return tiles_per_line / tile_per_row;
    endfunction

    function automatic int tile_lines(input int height_lns, input int tile_width);
        return height_lns / tile_width;
    endfunction

    function automatic int fbuff_data_width(input int tile_per_row, input int pxl_width);
        return tile_per_row * pxl_width;
    endfunction

    function automatic logic [PXL_MAX_W-1:0] lane_select(input logic [WORD_MAX_W-1:0] word,
                                                         input int lane, input int pxl_width);
        logic [WORD_MAX_W-1:0] shifted;
        logic [PXL_MAX_W-1:0]  mask;
        shifted = word >> (lane * pxl_width);
        mask    = ~({PXL_MAX_W{1'b1}} << pxl_width);
        return shifted[PXL_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/line_buff_ram.sv
// Tile-line storage: one write port for the fill engine and one synchronous
// read port for the display path.
module line_buff_ram #(
    parameter int DEPTH  = 80,
    parameter int DATA_W = 48,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/multi_line_buffer.sv
// Ring of tile-line buffers between the frame buffer and the VGA colour stage:
// a fill engine prefetches tile lines, the display side replays them per pixel.
module multi_line_buffer
    import line_buff_pkg::*;
#(
    parameter int  PXL_WIDTH         = 12,
    parameter int  TILE_WIDTH        = 4,
    parameter int  WIDTH_PX          = 640,
    parameter int  HEIGHT_LNS        = 480,
    parameter int  TILE_PER_ROW      = 4,
    parameter int  NUM_BUFS          = 2,
    parameter int  H_B_PORCH_MAX_PX  = 144,
    parameter int  V_B_PORCH_MAX_LNS = 35,
    parameter int  PXL_CTR_WIDTH     = 10,
    parameter int  LN_CTR_WIDTH      = 10,
    parameter int  FBUFF_ADDR_WIDTH  = 15,
    localparam int TILE_PER_LINE     = tile_per_line(WIDTH_PX, TILE_WIDTH),
    localparam int ROWS_PER_LINE     = rows_per_line(TILE_PER_LINE, TILE_PER_ROW),
    localparam int TILE_LINES        = tile_lines(HEIGHT_LNS, TILE_WIDTH),
    localparam int FBUFF_DATA_WIDTH  = fbuff_data_width(TILE_PER_ROW, PXL_WIDTH)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [PXL_CTR_WIDTH-1:0]    pxl_cntr_i,
    input  logic [LN_CTR_WIDTH-1:0]     ln_cntr_i,
    input  logic                        fbuff_rd_rsp_i,
    input  logic [FBUFF_DATA_WIDTH-1:0] fbuff_data_i,
    output logic                        fbuff_rd_req_o,
    output logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addr_o,
    output logic [PXL_WIDTH-1:0]        disp_pxl_o,
    output logic                        fill_busy_o,
    output logic                        underrun_o
);

    localparam int PTR_W   = $clog2(NUM_BUFS);
    localparam int CNT_W   = $clog2(NUM_BUFS + 1);
    localparam int LINE_W  = $clog2(TILE_LINES);
    localparam int ROW_W   = $clog2(ROWS_PER_LINE);
    localparam int RAM_AW  = $clog2(NUM_BUFS * ROWS_PER_LINE);
    localparam int TILE_SH = $clog2(TILE_WIDTH);
    localparam int LANE_W  = $clog2(TILE_PER_ROW);
    localparam int H_END   = H_B_PORCH_MAX_PX + WIDTH_PX;
    localparam int V_END   = V_B_PORCH_MAX_LNS + HEIGHT_LNS;

    fill_state_t                 state, state_nxt;
    logic [PTR_W-1:0]            wr_ptr, rd_ptr;
    logic [CNT_W-1:0]            count;
    logic [LINE_W-1:0]           fill_line;
    logic [ROW_W-1:0]            row_idx;
    logic [PXL_CTR_WIDTH-1:0]    pxl_off, tile;
    logic [LN_CTR_WIDTH-1:0]     ln_off;
    logic                        in_region, release_pt, release_ok, fill_done, ram_we;
    logic [RAM_AW-1:0]           ram_wr_addr, ram_rd_addr;
    logic [FBUFF_DATA_WIDTH-1:0] ram_rd_data;
    logic                        vld_p1;
    logic [LANE_W-1:0]           lane_p1;

    assign in_region = (int'(pxl_cntr_i) >= H_B_PORCH_MAX_PX) && (int'(pxl_cntr_i) < H_END) &&
                       (int'(ln_cntr_i) >= V_B_PORCH_MAX_LNS) && (int'(ln_cntr_i) < V_END);
    assign pxl_off    = pxl_cntr_i - PXL_CTR_WIDTH'(H_B_PORCH_MAX_PX);
    assign tile       = pxl_off >> TILE_SH;
    assign ln_off     = ln_cntr_i - LN_CTR_WIDTH'(V_B_PORCH_MAX_LNS);
    // Last pixel of the last display line of a tile row frees the oldest buffer
    assign release_pt = in_region && (int'(pxl_cntr_i) == H_END - 1) && (&ln_off[TILE_SH-1:0]);
    assign release_ok = release_pt && (count != '0);
    assign fill_done  = (state == DONE);
    assign ram_we     = (state == WAIT) && fbuff_rd_rsp_i;

    assign ram_wr_addr  = RAM_AW'(int'(wr_ptr) * ROWS_PER_LINE + int'(row_idx));
    assign ram_rd_addr  = in_region ? RAM_AW'(int'(rd_ptr) * ROWS_PER_LINE + int'(tile >> LANE_W)) : '0;
    assign fbuff_addr_o = FBUFF_ADDR_WIDTH'(int'(fill_line) * ROWS_PER_LINE + int'(row_idx));
    assign fill_busy_o  = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        fbuff_rd_req_o = 1'b0;
        case (state)
            IDLE: if (count < CNT_W'(NUM_BUFS)) state_nxt = REQ;
            REQ: begin
                fbuff_rd_req_o = 1'b1;
                state_nxt      = WAIT;
            end
            WAIT: if (fbuff_rd_rsp_i) state_nxt = (row_idx == ROW_W'(ROWS_PER_LINE - 1)) ? DONE : REQ;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fill_line <= '0;
            row_idx   <= '0;
        end else begin
            if (ram_we && (row_idx != ROW_W'(ROWS_PER_LINE - 1))) begin
                row_idx <= row_idx + ROW_W'(1);
            end
            if (fill_done) begin
                row_idx   <= '0;
                wr_ptr    <= (wr_ptr == PTR_W'(NUM_BUFS - 1)) ? '0 : wr_ptr + PTR_W'(1);
                fill_line <= (fill_line == LINE_W'(TILE_LINES - 1)) ? '0 : fill_line + LINE_W'(1);
            end
            if (release_ok) begin
                rd_ptr <= (rd_ptr == PTR_W'(NUM_BUFS - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (fill_done && !release_ok) begin
                count <= count + CNT_W'(1);
            end else if (!fill_done && release_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    line_buff_ram #(
        .DEPTH (NUM_BUFS * ROWS_PER_LINE),
        .DATA_W(FBUFF_DATA_WIDTH),
        .ADDR_W(RAM_AW)
    ) u_ram (
        .clk    (clk_i),
        .wr_en  (ram_we),
        .wr_addr(ram_wr_addr),
        .wr_data(fbuff_data_i),
        .rd_addr(ram_rd_addr),
        .rd_data(ram_rd_data)
    );

    // Stage p1: lane and qualifiers registered alongside the synchronous RAM read
    always_ff @(posedge clk_i) begin
        lane_p1 <= tile[LANE_W-1:0];
        if (rst_i) begin
            vld_p1     <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            vld_p1 <= in_region && (count != '0);
            if (in_region && (count == '0)) begin
                underrun_o <= 1'b1;
            end
        end
    end

    assign disp_pxl_o = vld_p1 ?
        PXL_WIDTH'(lane_select(WORD_MAX_W'(ram_rd_data), int'(lane_p1), PXL_WIDTH)) : '0;

endmodule

// File: tb/tb_multi_line_buffer.sv
// Self-checking bench for multi_line_buffer: two instances (2- and 4-deep rings)
// share counters; each has its own frame-buffer model with one-cycle latency.
module tb_multi_line_buffer;

    localparam int PW  = 12;
    localparam int FW  = 48;
    localparam int AW  = 15;
    localparam int GAP = 100;
    localparam int NB [2] = '{2, 4};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [9:0]    pxl = '0;
    logic [9:0]    ln  = '0;
    logic          rsp  [2] = '{1'b0, 1'b0};
    logic [FW-1:0] data [2] = '{default: '0};
    logic          req  [2];
    logic [AW-1:0] addr [2];
    logic [PW-1:0] disp [2];
    logic          busy [2];
    logic          underrun [2];

    int            checks = 0;
    int            errors = 0;
    bit            respond_en = 1'b1;
    bit            pend  [2] = '{1'b0, 1'b0};
    logic [AW-1:0] paddr [2] = '{default: '0};
    logic [AW-1:0] log_q [2][$];
    logic [AW-1:0] exp_q [2][$];
    logic [PW-1:0] exp_pix_q [$];

    always #5 clk = ~clk;

    multi_line_buffer u_dut2 (
        .clk_i(clk), .rst_i(rst), .pxl_cntr_i(pxl), .ln_cntr_i(ln),
        .fbuff_rd_rsp_i(rsp[0]), .fbuff_data_i(data[0]), .fbuff_rd_req_o(req[0]),
        .fbuff_addr_o(addr[0]), .disp_pxl_o(disp[0]), .fill_busy_o(busy[0]),
        .underrun_o(underrun[0])
    );

    multi_line_buffer #(.NUM_BUFS(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .pxl_cntr_i(pxl), .ln_cntr_i(ln),
        .fbuff_rd_rsp_i(rsp[1]), .fbuff_data_i(data[1]), .fbuff_rd_req_o(req[1]),
        .fbuff_addr_o(addr[1]), .disp_pxl_o(disp[1]), .fill_busy_o(busy[1]),
        .underrun_o(underrun[1])
    );

    function automatic logic [FW-1:0] fb_word(input logic [AW-1:0] a);
        logic [FW-1:0] w;
        for (int j = 0; j < 4; j++) w[j*PW +: PW] = PW'(4 * int'(a) + j);
        return w;
    endfunction

    function automatic logic [PW-1:0] exp_pix(input int l, input int p);
        int t, tl, k;
        if (l < 35 || l >= 515 || p < 144 || p >= 784) return '0;
        t  = (l - 35) / 4;
        tl = (p - 144) / 4;
        k  = t * 40 + tl / 4;
        return PW'(4 * k + tl % 4);
    endfunction

    // Frame-buffer models: a request seen in one cycle is answered in the next
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            rsp[d] = 1'b0;
            if (pend[d]) begin
                rsp[d]  = 1'b1;
                data[d] = fb_word(paddr[d]);
                pend[d] = 1'b0;
            end
            if (req[d] === 1'b1) begin
                log_q[d].push_back(addr[d]);
                if (respond_en) begin
                    pend[d]  = 1'b1;
                    paddr[d] = addr[d];
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input int d, input int line);
        for (int r = 0; r < 40; r++) exp_q[d].push_back(AW'(line * 40 + r));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cycle();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req[d] !== 1'b0 || addr[d] !== '0 || disp[d] !== '0 || busy[d] !== 1'b0 || underrun[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: req=%b addr=%0d disp=%0h busy=%b underrun=%b, required all 0",
                         d, req[d], addr[d], disp[d], busy[d], underrun[d]);
            end
        end
        rst = 1'b0;
        cycle();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req[d] !== 1'b1 || addr[d] !== '0) begin
                errors++;
                $display("FAIL first_req dut%0d: req=%b addr=%0d, required req=1 addr=0", d, req[d], addr[d]);
            end
        end
        repeat (20) cycle();
        rst = 1'b1;
        repeat (3) cycle();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req[d] !== 1'b0 || addr[d] !== '0 || disp[d] !== '0 || busy[d] !== 1'b0 || underrun[d] !== 1'b0) begin
                errors++;
                $display("FAIL midfill_reset dut%0d: req=%b addr=%0d disp=%0h busy=%b underrun=%b, required all 0",
                         d, req[d], addr[d], disp[d], busy[d], underrun[d]);
            end
        end
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            log_q[d].delete();
            for (int l = 0; l < NB[d]; l++) push_line(d, l);
        end
        cycle();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req[d] !== 1'b1 || addr[d] !== '0) begin
                errors++;
                $display("FAIL restart_req dut%0d: req=%b addr=%0d, required req=1 addr=0", d, req[d], addr[d]);
            end
        end
    endtask

    task automatic test_prefetch();
        int k = 0;
        int bc [2] = '{0, 0};
        logic [AW-1:0] a, e;
        while ((log_q[0].size() < 80 || log_q[1].size() < 160 || busy[0] || busy[1]) && k < 2000) begin
            cycle();
            k++;
        end
        checks++;
        if (k >= 2000) begin
            errors++;
            $display("FAIL prefetch_timeout: waited %0d cycles, required fewer than 2000", k);
        end
        for (int d = 0; d < 2; d++) begin
            while (log_q[d].size() > 0) begin
                a = log_q[d].pop_front();
                checks++;
                if (exp_q[d].size() == 0) begin
                    errors++;
                    $display("FAIL prefetch_addr dut%0d: got %0d, required no request", d, a);
                end else begin
                    e = exp_q[d].pop_front();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL prefetch_addr dut%0d: got %0d, required %0d", d, a, e);
                    end
                end
            end
            checks++;
            if (exp_q[d].size() != 0) begin
                errors++;
                $display("FAIL prefetch_missing dut%0d: %0d addresses not issued, required 0", d, exp_q[d].size());
            end
        end
        repeat (50) begin
            cycle();
            for (int d = 0; d < 2; d++) if (busy[d] !== 1'b0 || req[d] !== 1'b0) bc[d]++;
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (bc[d] != 0) begin
                errors++;
                $display("FAIL idle_after_prefetch dut%0d: busy for %0d cycles, required 0", d, bc[d]);
            end
        end
    endtask

    task automatic test_display();
        int px [9] = '{143, 144, 145, 146, 147, 148, 200, 783, 784};
        logic [PW-1:0] e;
        ln = 10'd35;
        for (int i = 0; i < 9; i++) begin
            pxl = 10'(px[i]);
            exp_pix_q.push_back(exp_pix(35, px[i]));
            cycle();
            e = exp_pix_q.pop_front();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (disp[d] !== e || underrun[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL display_px%0d dut%0d: disp=%0d underrun=%b, required disp=%0d underrun=0",
                             px[i], d, disp[d], underrun[d], e);
                end
            end
        end
        pxl = '0;
    endtask

    task automatic test_release();
        logic [PW-1:0] e;
        logic [AW-1:0] a, x;
        ln  = 10'd38;
        pxl = 10'd783;
        exp_pix_q.push_back(exp_pix(38, 783));
        for (int d = 0; d < 2; d++) push_line(d, NB[d]);
        cycle();
        e = exp_pix_q.pop_front();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (disp[d] !== e || underrun[d] !== 1'b0) begin
                errors++;
                $display("FAIL release_px dut%0d: disp=%0d underrun=%b, required disp=%0d underrun=0",
                         d, disp[d], underrun[d], e);
            end
        end
        ln  = 10'd39;
        pxl = '0;
        repeat (GAP) cycle();
        for (int d = 0; d < 2; d++) begin
            while (log_q[d].size() > 0) begin
                a = log_q[d].pop_front();
                checks++;
                if (exp_q[d].size() == 0) begin
                    errors++;
                    $display("FAIL release_addr dut%0d: got %0d, required no request", d, a);
                end else begin
                    x = exp_q[d].pop_front();
                    if (a !== x) begin
                        errors++;
                        $display("FAIL release_addr dut%0d: got %0d, required %0d", d, a, x);
                    end
                end
            end
        end
        pxl = 10'd150;
        exp_pix_q.push_back(exp_pix(39, 150));
        cycle();
        e = exp_pix_q.pop_front();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (disp[d] !== e) begin
                errors++;
                $display("FAIL second_tile_line dut%0d: disp=%0d, required %0d", d, disp[d], e);
            end
        end
        pxl = '0;
    endtask

    task automatic test_frame_wrap();
        logic [PW-1:0] e;
        logic [AW-1:0] a, x;
        int t, sp;
        for (int n = 1; n <= 124; n++) begin
            t   = n % 120;
            ln  = 10'(35 + 4 * t);
            pxl = '0;
            repeat (GAP) cycle();
            for (int d = 0; d < 2; d++) begin
                while (log_q[d].size() > 0) begin
                    a = log_q[d].pop_front();
                    checks++;
                    if (exp_q[d].size() == 0) begin
                        errors++;
                        $display("FAIL wrap_addr dut%0d: got %0d, required no request", d, a);
                    end else begin
                        x = exp_q[d].pop_front();
                        if (a !== x) begin
                            errors++;
                            $display("FAIL wrap_addr dut%0d: got %0d, required %0d", d, a, x);
                        end
                    end
                end
            end
            if (n == 124) break;
            for (int s = 0; s < 2; s++) begin
                sp  = (s == 0) ? 144 + (n * 37) % 640 : 783;
                ln  = 10'(35 + 4 * t + 3 * s);
                pxl = 10'(sp);
                exp_pix_q.push_back(exp_pix(int'(ln), sp));
                if (s == 1) for (int d = 0; d < 2; d++) push_line(d, (t + NB[d]) % 120);
                cycle();
                e = exp_pix_q.pop_front();
                for (int d = 0; d < 2; d++) begin
                    checks++;
                    if (disp[d] !== e || underrun[d] !== 1'b0) begin
                        errors++;
                        $display("FAIL wrap_pixel n%0d ln%0d px%0d dut%0d: disp=%0d underrun=%b, required disp=%0d underrun=0",
                                 n, ln, sp, d, disp[d], underrun[d], e);
                    end
                end
            end
        end
        pxl = '0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (exp_q[d].size() != 0) begin
                errors++;
                $display("FAIL wrap_missing dut%0d: %0d addresses not issued, required 0", d, exp_q[d].size());
            end
        end
    endtask

    task automatic test_underrun();
        int px [2] = '{144, 200};
        respond_en = 1'b0;
        rst = 1'b1;
        ln  = '0;
        pxl = '0;
        repeat (3) cycle();
        rst = 1'b0;
        repeat (20) cycle();
        ln = 10'd35;
        for (int i = 0; i < 2; i++) begin
            pxl = 10'(px[i]);
            cycle();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (disp[d] !== '0 || underrun[d] !== 1'b1) begin
                    errors++;
                    $display("FAIL underrun_px%0d dut%0d: disp=%0d underrun=%b, required disp=0 underrun=1",
                             px[i], d, disp[d], underrun[d]);
                end
            end
        end
        ln  = '0;
        pxl = '0;
        repeat (10) cycle();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (underrun[d] !== 1'b1) begin
                errors++;
                $display("FAIL underrun_sticky dut%0d: underrun=%b, required 1", d, underrun[d]);
            end
        end
        rst = 1'b1;
        cycle();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (underrun[d] !== 1'b0) begin
                errors++;
                $display("FAIL underrun_clear dut%0d: underrun=%b, required 0", d, underrun[d]);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_prefetch();
        test_display();
        test_release();
        test_frame_wrap();
        test_underrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
